blackjack_round_controller: RTL and testbench
=============================================

Name: blackjack_round_controller

Overview:
- FSM that runs one blackjack round by sequencing the card generator.
- Issues single-cycle draw pulses and captures each returned card value (2..11, where 11 = ace).
- Deals alternately to player and dealer, then keeps player and dealer totals with soft-ace handling.
- Runs the player turn from hit/stand buttons, auto-plays the dealer to 17, and reports the outcome to display/LED logic.

Parameters:
- DEALER_STAND, 17, dealer stops drawing once total >= this value (stands on soft 17).
- BJ_LIMIT, 21, bust threshold and player auto-stand value.

Ports:
- clk  input  1  system clock; also drives the card generator counter.
- rst  input  1  synchronous, active-high reset.
- start  input  1  begin round; level, sampled in IDLE and DONE only.
- player_hit  input  1  button level; acted on at its rising edge only.
- player_stand  input  1  button level; acted on at its rising edge only.
- card_in  input  4  card value from the generator.
- gen_hit  output  1  draw pulse to the generator; registered, high exactly 1 cycle.
- player_sum  output  5  player hand total after ace adjustment.
- dealer_sum  output  5  dealer hand total after ace adjustment.
- dealer_up  output  4  dealer's first card; 0 until dealt.
- player_turn  output  1  high in PLAYER state.
- result  output  2  00 none, 01 player win, 10 dealer win, 11 push.
- done  output  1  high in DONE state.

Behaviour:
- Reset (rst=1 at posedge clk):
  - state=IDLE; gen_hit, player_sum, dealer_sum, dealer_up, result, done, player_turn all 0.
  - Ace counters, deal index and edge-detect registers cleared.
  - Applies mid-round; gen_hit is 0 from the next edge.
- States: IDLE, REQ, CAP, PLAYER, DEALER, DONE.
  - IDLE: start=1 -> clear sums/aces/result, deal_idx=0, go to REQ.
  - REQ: gen_hit=1 for this cycle, go to CAP.
  - CAP: sample card_in (one cycle after the gen_hit rising edge) and add it to the target hand.
    - Target during initial deal: deal_idx 0,2 -> player; 1,3 -> dealer. dealer_up is loaded at deal_idx=1.
    - After the add, the next state is:
      - deal_idx<3: deal_idx++, go to REQ.
      - deal_idx==3 (initial deal complete): go to PLAYER.
      - player draw: go to PLAYER.
      - dealer draw: go to DEALER.
  - PLAYER: player_turn=1. Checks in priority order:
    - player_sum>21: result=10, go to DONE.
    - player_sum==21: go to DEALER (auto-stand).
    - stand rise: go to DEALER.
    - hit rise: go to REQ (target player).
    - Simultaneous hit and stand rises: stand wins.
  - DEALER: one decision per cycle.
    - dealer_sum<DEALER_STAND: go to REQ (target dealer).
    - Otherwise go to DONE and set result from the compare:
      - dealer_sum>21 or player_sum>dealer_sum -> 01.
      - equal -> 11.
      - else -> 10.
  - DONE: done=1; result and sums held. start=1 begins a new round exactly as from IDLE.
- Card clamp at capture: card_in 0/1 -> 2; 12..15 -> 10. Any clamped value (which includes 10) is never counted as an ace.
- Hand arithmetic, on each capture:
  - Add in 6 bits: t = sum + card. card==11 increments that hand's ace count (3 bits).
  - If t>21 and aces>0: t -= 10, aces--.
  - Repeat once more in the same cycle if still needed (covers two aces).
  - Result truncated to 5 bits; the max reachable value is 30, so truncation is lossless.
- Input rules:
  - hit/stand edge registers update every cycle; rises outside PLAYER are ignored (not queued).
  - start during REQ/CAP/PLAYER/DEALER is ignored.
- Latency:
  - Each card takes 2 cycles (REQ, CAP).
  - Initial deal takes 8 cycles from the start-sampled edge to PLAYER.
  - DEALER->DONE takes 1 cycle once the stand condition holds.

Test Plan:
- Reset mid-round: assert rst in DEALER during a REQ cycle -> next cycle state IDLE, gen_hit=0, all outputs 0; a following start deals fresh.
- Basic round: card stream 10,9,7,8 -> player_sum=17, dealer_sum=17, dealer_up=9; stand -> result=11, done=1, no further gen_hit.
- Soft aces: stream 11,5,11,10 -> player_sum=12 with one ace left; hit with card 9 -> player_sum=21 -> auto DEALER; dealer 15 draws 4 -> 19 -> result=01.
- Player bust: stream 10,6,8,7; hit with card 5 -> player_sum=23 -> result=10, dealer never draws (exactly 5 gen_hit pulses total).
- Dealer draws to bust, then soft 17: stream 9,6,9,4 (dealer 10), stand, dealer draws 5 then 8 -> dealer_sum=23 -> result=01. Second round: dealer cards 11,6 -> stands at 17 without drawing.
- Edge and priority: hold player_hit high 10 cycles -> exactly one draw. Rising hit and stand in the same cycle -> DEALER entered, no player draw. card_in=14 -> counted as 10, not an ace.

Source files
------------

// File: rtl/blackjack_round_controller_if.sv
// Signal bundle between the round controller and its environment
// (buttons, card generator, display/LED logic).
interface blackjack_round_controller_if;
    logic       start;
    logic       player_hit;
    logic       player_stand;
    logic [3:0] card_in;
    logic       gen_hit;
    logic [4:0] player_sum;
    logic [4:0] dealer_sum;
    logic [3:0] dealer_up;
    logic       player_turn;
    logic [1:0] result;
    logic       done;

    modport master (
        output start, player_hit, player_stand, card_in,
        input  gen_hit, player_sum, dealer_sum, dealer_up, player_turn, result, done
    );

    modport slave (
        input  start, player_hit, player_stand, card_in,
        output gen_hit, player_sum, dealer_sum, dealer_up, player_turn, result, done
    );
endinterface

// File: rtl/blackjack_round_controller.sv
// Runs one blackjack round: deals four cards, runs the player turn from buttons,
// auto-plays the dealer and reports the outcome. All outputs are registered.
module blackjack_round_controller #(
    parameter int DEALER_STAND = 17,
    parameter int BJ_LIMIT     = 21
) (
    input logic                        clk,
    input logic                        rst,
    blackjack_round_controller_if.slave bus
);
    typedef enum logic [2:0] {IDLE, REQ, CAP, PLAYER, DEALER, DONE} state_t;

    state_t     state_reg;
    logic       gen_hit_reg;
    logic [4:0] player_sum_reg;
    logic [4:0] dealer_sum_reg;
    logic [2:0] player_aces_reg;
    logic [2:0] dealer_aces_reg;
    logic [3:0] dealer_up_reg;
    logic       player_turn_reg;
    logic [1:0] result_reg;
    logic       done_reg;
    logic [1:0] deal_idx_reg;
    logic       dealing_reg;
    logic       draw_dealer_reg;
    logic       hit_prev_reg;
    logic       stand_prev_reg;

    logic [3:0] card_clamped;
    logic       card_is_ace;
    logic       to_dealer;
    logic       hit_rise;
    logic       stand_rise;
    logic [4:0] hand_sum  [2];
    logic [2:0] hand_aces [2];
    logic [7:0] hand_add  [2];

    // Soft-ace fold: at most two 10-point reductions are ever needed per card.
    function automatic logic [7:0] add_card(input logic [4:0] sum, input logic [2:0] aces,
                                            input logic [3:0] card, input logic is_ace);
        logic [5:0] t;
        logic [2:0] a;
        t = {1'b0, sum} + {2'b00, card};
        a = aces + {2'b00, is_ace};
        for (int i = 0; i < 2; i++) begin
            if (t > 6'(BJ_LIMIT) && a != 3'd0) begin
                t = t - 6'd10;
                a = a - 3'd1;
            end
        end
        return {t[4:0], a};
    endfunction

    always_comb begin
        card_clamped = bus.card_in;
        if (bus.card_in < 4'd2)
            card_clamped = 4'd2;
        else if (bus.card_in > 4'd11)
            card_clamped = 4'd10;
    end

    assign card_is_ace = (bus.card_in == 4'd11);
    assign to_dealer   = dealing_reg ? deal_idx_reg[0] : draw_dealer_reg;
    assign hit_rise    = bus.player_hit & ~hit_prev_reg;
    assign stand_rise  = bus.player_stand & ~stand_prev_reg;

    assign hand_sum[0]  = player_sum_reg;
    assign hand_sum[1]  = dealer_sum_reg;
    assign hand_aces[0] = player_aces_reg;
    assign hand_aces[1] = dealer_aces_reg;

    // Index 0 is the player hand, index 1 the dealer hand.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_hand
            assign hand_add[gi] = add_card(hand_sum[gi], hand_aces[gi], card_clamped, card_is_ace);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg       <= IDLE;
            gen_hit_reg     <= 1'b0;
            player_sum_reg  <= '0;
            dealer_sum_reg  <= '0;
            player_aces_reg <= '0;
            dealer_aces_reg <= '0;
            dealer_up_reg   <= '0;
            player_turn_reg <= 1'b0;
            result_reg      <= 2'b00;
            done_reg        <= 1'b0;
            deal_idx_reg    <= '0;
            dealing_reg     <= 1'b0;
            draw_dealer_reg <= 1'b0;
            hit_prev_reg    <= 1'b0;
            stand_prev_reg  <= 1'b0;
        end else begin
            hit_prev_reg    <= bus.player_hit;
            stand_prev_reg  <= bus.player_stand;
            gen_hit_reg     <= 1'b0;
            player_turn_reg <= 1'b0;
            done_reg        <= 1'b0;
            case (state_reg)
                IDLE, DONE: begin
                    if (bus.start) begin
                        player_sum_reg  <= '0;
                        dealer_sum_reg  <= '0;
                        player_aces_reg <= '0;
                        dealer_aces_reg <= '0;
                        dealer_up_reg   <= '0;
                        result_reg      <= 2'b00;
                        deal_idx_reg    <= '0;
                        dealing_reg     <= 1'b1;
                        gen_hit_reg     <= 1'b1;
                        state_reg       <= REQ;
                    end else if (state_reg == DONE) begin
                        done_reg <= 1'b1;
                    end
                end
                REQ: state_reg <= CAP;
                CAP: begin
                    if (to_dealer)
                        {dealer_sum_reg, dealer_aces_reg} <= hand_add[1];
                    else
                        {player_sum_reg, player_aces_reg} <= hand_add[0];
                    if (dealing_reg && deal_idx_reg == 2'd1)
                        dealer_up_reg <= card_clamped;
                    if (dealing_reg && deal_idx_reg != 2'd3) begin
                        deal_idx_reg <= deal_idx_reg + 2'd1;
                        gen_hit_reg  <= 1'b1;
                        state_reg    <= REQ;
                    end else if (dealing_reg || !draw_dealer_reg) begin
                        dealing_reg     <= 1'b0;
                        player_turn_reg <= 1'b1;
                        state_reg       <= PLAYER;
                    end else begin
                        state_reg <= DEALER;
                    end
                end
                PLAYER: begin
                    if (player_sum_reg > 5'(BJ_LIMIT)) begin
                        result_reg <= 2'b10;
                        done_reg   <= 1'b1;
                        state_reg  <= DONE;
                    end else if (player_sum_reg == 5'(BJ_LIMIT) || stand_rise) begin
                        state_reg <= DEALER;
                    end else if (hit_rise) begin
                        draw_dealer_reg <= 1'b0;
                        gen_hit_reg     <= 1'b1;
                        state_reg       <= REQ;
                    end else begin
                        player_turn_reg <= 1'b1;
                    end
                end
                DEALER: begin
                    if (dealer_sum_reg < 5'(DEALER_STAND)) begin
                        draw_dealer_reg <= 1'b1;
                        gen_hit_reg     <= 1'b1;
                        state_reg       <= REQ;
                    end else begin
                        done_reg  <= 1'b1;
                        state_reg <= DONE;
                        if (dealer_sum_reg > 5'(BJ_LIMIT) || player_sum_reg > dealer_sum_reg)
                            result_reg <= 2'b01;
                        else if (player_sum_reg == dealer_sum_reg)
                            result_reg <= 2'b11;
                        else
                            result_reg <= 2'b10;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign bus.gen_hit     = gen_hit_reg;
    assign bus.player_sum  = player_sum_reg;
    assign bus.dealer_sum  = dealer_sum_reg;
    assign bus.dealer_up   = dealer_up_reg;
    assign bus.player_turn = player_turn_reg;
    assign bus.result      = result_reg;
    assign bus.done        = done_reg;
endmodule

// File: tb/tb_blackjack_round_controller.sv
// Randomized and directed blackjack rounds checked against a hand-value model
// that scores whole hands (aces as 11, demoted to 1 only while over 21).
module tb_blackjack_round_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    blackjack_round_controller_if bus ();

    blackjack_round_controller #(.DEALER_STAND(17), .BJ_LIMIT(21)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;
    int deck [64];
    int deck_pos  = 0;
    int pulse_cnt = 0;
    logic gen_prev = 1'b0;
    int stream [40];

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Card generator: answers each draw pulse with the next deck card.
    always @(negedge clk) begin
        if (bus.gen_hit) begin
            check("gen_hit_width", int'(gen_prev), 0);
            bus.card_in = 4'(deck[deck_pos % 64]);
            deck_pos++;
            pulse_cnt++;
        end
        gen_prev = bus.gen_hit;
    end

    function automatic int clampc(input int c);
        if (c < 2) return 2;
        if (c > 11) return 10;
        return c;
    endfunction

    function automatic int hand_val(input int raw, input int aces);
        int v;
        int a;
        v = raw;
        a = aces;
        while (v > 21 && a > 0) begin
            v -= 10;
            a--;
        end
        return v;
    endfunction

    task automatic take(inout int raw, inout int aces, input int c);
        raw += clampc(c);
        if (c == 11) aces++;
    endtask

    task automatic wait_turn();
        for (int i = 0; i < 50 && !bus.player_turn; i++) @(negedge clk);
        check("turn_wait", int'(bus.player_turn), 1);
    endtask

    task automatic wait_done();
        for (int i = 0; i < 100 && !bus.done; i++) @(negedge clk);
        check("done_wait", int'(bus.done), 1);
    endtask

    // Loads the stream into the deck, pulses start and waits out the 8-cycle deal.
    task automatic start_deal(output int base);
        for (int k = 0; k < 40; k++) deck[(deck_pos + k) % 64] = stream[k];
        base = pulse_cnt;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        check("deal_turn", int'(bus.player_turn), 1);
        check("deal_pulses", pulse_cnt - base, 4);
    endtask

    task automatic play_round(input string name, input int thr);
        int pr, pa, dr, da, idx, nh, nd, pv, dv, exp_res, base, after;
        int hit_pv [20];
        pr = 0; pa = 0; dr = 0; da = 0; nh = 0; nd = 0;
        take(pr, pa, stream[0]);
        take(dr, da, stream[1]);
        take(pr, pa, stream[2]);
        take(dr, da, stream[3]);
        idx = 4;
        start_deal(base);
        check({name, "_deal_psum"}, int'(bus.player_sum), hand_val(pr, pa));
        check({name, "_deal_dsum"}, int'(bus.dealer_sum), hand_val(dr, da));
        check({name, "_dealer_up"}, int'(bus.dealer_up), clampc(stream[1]));
        while (hand_val(pr, pa) < 21 && hand_val(pr, pa) < thr) begin
            hit_pv[nh] = hand_val(pr, pa);
            take(pr, pa, stream[idx]);
            idx++;
            nh++;
        end
        pv = hand_val(pr, pa);
        if (pv > 21) begin
            exp_res = 2;
        end else begin
            while (hand_val(dr, da) < 17) begin
                take(dr, da, stream[idx]);
                idx++;
                nd++;
            end
            if (hand_val(dr, da) > 21 || pv > hand_val(dr, da)) exp_res = 1;
            else if (pv == hand_val(dr, da)) exp_res = 3;
            else exp_res = 2;
        end
        dv = hand_val(dr, da);
        for (int h = 0; h < nh; h++) begin
            wait_turn();
            check({name, "_hit_psum"}, int'(bus.player_sum), hit_pv[h]);
            bus.player_hit = 1'b1;
            @(negedge clk);
            bus.player_hit = 1'b0;
        end
        if (pv < 21) begin
            wait_turn();
            bus.player_stand = 1'b1;
            @(negedge clk);
            bus.player_stand = 1'b0;
        end
        wait_done();
        check({name, "_result"}, int'(bus.result), exp_res);
        check({name, "_psum"}, int'(bus.player_sum), pv);
        check({name, "_dsum"}, int'(bus.dealer_sum), dv);
        check({name, "_pulses"}, pulse_cnt - base, 4 + nh + nd);
        check({name, "_turn_low"}, int'(bus.player_turn), 0);
        after = pulse_cnt;
        repeat (3) @(negedge clk);
        check({name, "_no_more_draws"}, pulse_cnt - after, 0);
        check({name, "_done_held"}, int'(bus.done), 1);
        $display("round %s thr=%0d player=%0d dealer=%0d hits=%0d dealer_draws=%0d result=%0d",
                 name, thr, pv, dv, nh, nd, exp_res);
    endtask

    task automatic set_stream(input int c0, input int c1, input int c2, input int c3,
                              input int c4, input int c5, input int c6);
        for (int k = 0; k < 40; k++) stream[k] = int'($urandom_range(0, 15));
        stream[0] = c0; stream[1] = c1; stream[2] = c2; stream[3] = c3;
        stream[4] = c4; stream[5] = c5; stream[6] = c6;
    endtask

    task automatic check_cleared(input string tag);
        check({tag, "_gen_hit"}, int'(bus.gen_hit), 0);
        check({tag, "_psum"}, int'(bus.player_sum), 0);
        check({tag, "_dsum"}, int'(bus.dealer_sum), 0);
        check({tag, "_up"}, int'(bus.dealer_up), 0);
        check({tag, "_turn"}, int'(bus.player_turn), 0);
        check({tag, "_result"}, int'(bus.result), 0);
        check({tag, "_done"}, int'(bus.done), 0);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.player_hit = 1'b0;
        bus.player_stand = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check_cleared("reset");
        $display("reset state checked");

        set_stream(10, 9, 7, 8, 5, 5, 5);  play_round("basic", 0);
        set_stream(11, 5, 11, 10, 9, 4, 5); play_round("soft_aces", 13);
        set_stream(10, 6, 8, 7, 5, 5, 5);  play_round("player_bust", 19);
        set_stream(9, 6, 9, 4, 5, 8, 5);   play_round("dealer_bust", 0);
        set_stream(10, 11, 8, 6, 5, 5, 5); play_round("soft17", 0);
        set_stream(14, 11, 14, 6, 5, 5, 5); play_round("card14", 0);

        // Held hit gives one draw; simultaneous hit+stand rise is a stand.
        set_stream(2, 2, 3, 3, 2, 10, 2);
        start_deal(base);
        bus.player_hit = 1'b1;
        repeat (10) @(negedge clk);
        bus.player_hit = 1'b0;
        wait_turn();
        check("hold_hit_pulses", pulse_cnt - base, 5);
        check("hold_hit_psum", int'(bus.player_sum), 7);
        @(negedge clk);
        bus.player_hit = 1'b1;
        bus.player_stand = 1'b1;
        @(negedge clk);
        bus.player_hit = 1'b0;
        bus.player_stand = 1'b0;
        wait_done();
        check("both_rise_pulses", pulse_cnt - base, 7);
        check("both_rise_psum", int'(bus.player_sum), 7);
        check("both_rise_dsum", int'(bus.dealer_sum), 17);
        check("both_rise_result", int'(bus.result), 2);
        $display("edge/priority round: pulses=%0d", pulse_cnt - base);

        // Reset during a dealer draw request.
        set_stream(2, 2, 2, 2, 5, 5, 5);
        start_deal(base);
        bus.player_stand = 1'b1;
        @(negedge clk);
        bus.player_stand = 1'b0;
        for (int i = 0; i < 20 && !bus.gen_hit; i++) @(negedge clk);
        check("midreset_req_seen", int'(bus.gen_hit), 1);
        rst = 1'b1;
        @(negedge clk);
        check_cleared("midreset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("midreset_idle_pulses", int'(bus.gen_hit), 0);
        $display("mid-round reset checked");
        set_stream(10, 7, 6, 10, 5, 5, 5); play_round("after_reset", 17);

        for (int r = 0; r < 30; r++) begin
            for (int k = 0; k < 40; k++) stream[k] = int'($urandom_range(0, 15));
            play_round($sformatf("rand%0d", r), int'($urandom_range(12, 21)));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
